// File: rtl/pea_invoke_arbiter_if.sv
// Handshake bundle between the host/scheduler, the PEA cores and the invoke arbiter.
// The arbiter takes the slave view; the host side (or a bench) takes the master view.
interface pea_invoke_arbiter_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             invoke;
    logic [NCH-1:0]   en_ch;
    logic [NCH-1:0]   done_ch;
    logic [NCH-1:0]   start_ch;
    logic [NCH-1:0]   abort_ch;
    logic             busy;
    logic [CH_W-1:0]  active_ch;
    logic             FC;
    logic             no_fire;
    logic             timeout_err;
    logic [CNT_W-1:0] fire_count;

    modport master (
        output invoke, en_ch, done_ch,
        input  start_ch, abort_ch, busy, active_ch, FC, no_fire, timeout_err, fire_count
    );

    modport slave (
        input  invoke, en_ch, done_ch,
        output start_ch, abort_ch, busy, active_ch, FC, no_fire, timeout_err, fire_count
    );
endinterface

// File: rtl/pea_invoke_arbiter.sv
// Round-robin invoke controller for NCH PEA cores: picks one enabled core per
// invoke, pulses its start, then waits for its done with a watchdog.
// All outputs are registered; pulse outputs are exactly one cycle wide.
module pea_invoke_arbiter #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    pea_invoke_arbiter_if.slave bus
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_START  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // One-hot decode of a core index.
    function automatic logic [NCH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
        return NCH'(1'b1) << idx;
    endfunction

    state_t           state_r, state_s;
    logic [CH_W-1:0]  last_grant_r, last_grant_s;
    logic [CH_W-1:0]  active_ch_r, active_ch_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [CNT_W-1:0] fire_count_r, fire_count_s;
    logic [NCH-1:0]   start_ch_r, start_ch_s;
    logic [NCH-1:0]   abort_ch_r, abort_ch_s;
    logic             fc_r, fc_s;
    logic             no_fire_r, no_fire_s;
    logic             timeout_err_r, timeout_err_s;
    logic             busy_r, busy_s;

    logic             grant_found_s;
    logic [CH_W-1:0]  grant_idx_s;
    logic [NCH-1:0]   en_shift_s;
    int unsigned      scan_idx_s;
    logic             done_sel_s;

    // Round-robin search: first enabled core after the last granted one, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        en_shift_s    = '0;
        scan_idx_s    = 0;
        for (int i = 1; i <= NCH; i++) begin
            scan_idx_s    = (int'(last_grant_r) + i) % NCH;
            en_shift_s    = bus.en_ch >> scan_idx_s;
            grant_idx_s   = (!grant_found_s && en_shift_s[0]) ? CH_W'(scan_idx_s) : grant_idx_s;
            grant_found_s = grant_found_s | en_shift_s[0];
        end
    end

    // Only the granted core's done bit is of interest; all others are ignored.
    always_comb begin
        done_sel_s = |(bus.done_ch & ch_onehot(active_ch_r));
    end

    // Next-state and next-output logic; everything holds or clears by default.
    always_comb begin
        state_s       = state_r;
        last_grant_s  = last_grant_r;
        active_ch_s   = active_ch_r;
        timer_s       = timer_r;
        fire_count_s  = fire_count_r;
        start_ch_s    = '0;
        abort_ch_s    = '0;
        fc_s          = 1'b0;
        no_fire_s     = 1'b0;
        timeout_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.invoke) begin
                    state_s = ST_SELECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (grant_found_s) begin
                    active_ch_s = grant_idx_s;
                    start_ch_s  = ch_onehot(grant_idx_s);
                    state_s     = ST_START;
                end else begin
                    no_fire_s = 1'b1;
                    state_s   = ST_IDLE;
                end
            end
            ST_START: begin
                timer_s = '0;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_sel_s) begin
                    // Done wins over a coincident watchdog expiry.
                    fc_s         = 1'b1;
                    fire_count_s = fire_count_r + CNT_W'(1'b1);
                    last_grant_s = active_ch_r;
                    state_s      = ST_IDLE;
                end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
                    timeout_err_s = 1'b1;
                    abort_ch_s    = ch_onehot(active_ch_r);
                    last_grant_s  = active_ch_r;
                    state_s       = ST_IDLE;
                end else begin
                    timer_s = timer_r + TMR_W'(1'b1);
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset abandons any firing without pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= CH_W'(NCH - 1);
            active_ch_r   <= '0;
            timer_r       <= '0;
            fire_count_r  <= '0;
            start_ch_r    <= '0;
            abort_ch_r    <= '0;
            fc_r          <= 1'b0;
            no_fire_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            last_grant_r  <= last_grant_s;
            active_ch_r   <= active_ch_s;
            timer_r       <= timer_s;
            fire_count_r  <= fire_count_s;
            start_ch_r    <= start_ch_s;
            abort_ch_r    <= abort_ch_s;
            fc_r          <= fc_s;
            no_fire_r     <= no_fire_s;
            timeout_err_r <= timeout_err_s;
            busy_r        <= busy_s;
        end
    end

    assign bus.start_ch    = start_ch_r;
    assign bus.abort_ch    = abort_ch_r;
    assign bus.busy        = busy_r;
    assign bus.active_ch   = active_ch_r;
    assign bus.FC          = fc_r;
    assign bus.no_fire     = no_fire_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.fire_count  = fire_count_r;
endmodule

// File: tb/tb_pea_invoke_arbiter.sv
// Scoreboard bench for pea_invoke_arbiter: every expected output pulse is queued
// with its cycle when stimulus is driven, and popped when the DUT pulses.
module tb_pea_invoke_arbiter;
    localparam int NCH     = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 16;

    typedef struct {
        logic [63:0] outs;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    logic [CNT_W-1:0] exp_count;
    logic [1:0]       exp_active;

    pea_invoke_arbiter_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    pea_invoke_arbiter #(.NCH(NCH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Cycle number; cycle c runs from posedge c to posedge c+1.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pack(input logic [3:0] st, input logic [3:0] ab,
                                         input logic fc, input logic nf, input logic to,
                                         input logic [1:0] act, input logic [CNT_W-1:0] cnt);
        return {33'd0, st, ab, fc, nf, to, act, cnt};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [63:0] o);
        exp_t e;
        e.outs = o;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_outs"}, pack(bus.start_ch, bus.abort_ch, bus.FC, bus.no_fire,
                  bus.timeout_err, bus.active_ch, bus.fire_count),
                  pack(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, exp_active, exp_count));
        check_val({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    // Scoreboard monitor: any pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        logic [63:0] obs;
        exp_t e;
        if (mon_en) begin
            obs = pack(bus.start_ch, bus.abort_ch, bus.FC, bus.no_fire, bus.timeout_err,
                       bus.active_ch, bus.fire_count);
            if (bus.start_ch != 4'd0 || bus.abort_ch != 4'd0 || bus.FC || bus.no_fire ||
                bus.timeout_err) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_evt", obs, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("evt_out", obs, e.outs);
                    check_val("evt_cyc", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // One firing on expected core g; done arrives after wait_n WAIT cycles.
    // With stray set, a foreign done bit and an invoke are pulsed during WAIT.
    task automatic fire(input logic [3:0] en, input logic [1:0] g, input int wait_n, input bit stray);
        int k;
        int m;
        logic [3:0] oh;
        oh = 4'b0001 << g;
        k = cyc;
        bus.en_ch  = en;
        bus.invoke = 1'b1;
        push(k + 2, pack(oh, 4'd0, 1'b0, 1'b0, 1'b0, g, exp_count));
        exp_active = g;
        tick();
        bus.invoke = 1'b0;
        tick();
        tick();
        for (int j = 0; j < wait_n; j++) begin
            if (stray && j == 0) begin
                bus.done_ch = 4'b0001 << (g + 2'd1);
                bus.invoke  = 1'b1;
            end
            tick();
            bus.done_ch = 4'd0;
            bus.invoke  = 1'b0;
        end
        m = cyc;
        bus.done_ch = oh;
        exp_count = exp_count + 16'd1;
        push(m + 1, pack(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, g, exp_count));
        tick();
        bus.done_ch = 4'd0;
        tick();
    endtask

    initial begin
        int k;
        rst         = 1'b1;
        bus.invoke  = 1'b0;
        bus.en_ch   = 4'd0;
        bus.done_ch = 4'd0;
        exp_count   = '0;
        exp_active  = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
        check_idle("reset");
        mon_en = 1'b1;

        // Single firing: start in k+2, done in k+5, FC in k+6.
        fire(4'b1111, 2'd0, 2, 1'b0);
        check_val("count_single", 64'(bus.fire_count), 64'd1);

        // Round-robin over cores 1 and 3 at minimum invoke period.
        fire(4'b1010, 2'd1, 0, 1'b0);
        fire(4'b1010, 2'd3, 0, 1'b0);
        fire(4'b1010, 2'd1, 0, 1'b0);
        fire(4'b1010, 2'd3, 0, 1'b0);
        check_val("count_rr", 64'(bus.fire_count), 64'd5);

        // No enabled core: busy for one cycle, no_fire in k+2.
        k = cyc;
        bus.en_ch  = 4'd0;
        bus.invoke = 1'b1;
        push(k + 2, pack(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, exp_active, exp_count));
        tick();
        bus.invoke = 1'b0;
        check_val("nofire_busy_hi", 64'(bus.busy), 64'd1);
        tick();
        check_val("nofire_busy_lo", 64'(bus.busy), 64'd0);
        tick();
        fire(4'b1111, 2'd0, 1, 1'b0);

        // Watchdog on core 2: abort/timeout in START+TIMEOUT+1.
        k = cyc;
        bus.en_ch  = 4'b0100;
        bus.invoke = 1'b1;
        push(k + 2, pack(4'b0100, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, exp_count));
        push(k + 3 + TIMEOUT, pack(4'd0, 4'b0100, 1'b0, 1'b0, 1'b1, 2'd2, exp_count));
        exp_active = 2'd2;
        tick();
        bus.invoke = 1'b0;
        repeat (TIMEOUT + 2) tick();
        check_val("count_timeout", 64'(bus.fire_count), 64'(exp_count));
        fire(4'b1111, 2'd3, 1, 1'b0);

        // Stray done on another core plus an invoke during WAIT: both ignored.
        fire(4'b1111, 2'd0, 3, 1'b1);
        check_val("count_stray", 64'(bus.fire_count), 64'd8);

        // Reset during WAIT: no FC/abort, everything back to zero.
        k = cyc;
        bus.en_ch  = 4'b1111;
        bus.invoke = 1'b1;
        push(k + 2, pack(4'b0010, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, exp_count));
        tick();
        bus.invoke = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_count  = '0;
        exp_active = 2'd0;
        check_idle("midrst");
        repeat (TIMEOUT + 4) tick();
        check_idle("midrst_quiet");
        fire(4'b1111, 2'd0, 1, 1'b0);
        check_val("count_final", 64'(bus.fire_count), 64'd1);

        repeat (3) tick();
        check_val("leftover", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
